spi_xfer_ctrl: RTL
==================

// Module: spi_xfer_ctrl
// PURPOSE
// - SPI master transfer sequencer, mode 0 (CPOL=0, CPHA=0), MSB first.
// - Generates SCLK from CLK through an internal programmable tick divider, so no
//   derived clock is used. Drives CS_N/MOSI, samples MISO, and reports
//   completion to the WishBone register block through a START/BUSY/DONE handshake.
// PARAMETERS
// - DATA_W  8   bits per transfer (>=2)
// - CNT_W   16  width of the divider count / DIV_VAL port
// PORTS
// - CLK      in   1       system clock, single clock domain
// - RST      in   1       asynchronous, active-high reset
// - DIV_VAL  in   CNT_W   half-period of SCLK in CLK cycles, minus 1; sampled at START
// - START    in   1       transfer request; accepted only when BUSY=0
// - TX_DATA  in   DATA_W  word to send; sampled at START
// - BUSY     out  1       high from the cycle after START is accepted until DONE
// - DONE     out  1       one-cycle pulse; RX_DATA is valid from this cycle
// - RX_DATA  out  DATA_W  last received word; holds its value until the next DONE
// - SCLK     out  1       SPI clock, idles low
// - MOSI     out  1       SPI data out
// - MISO     in   1       SPI data in
// - CS_N     out  1       chip select, active low
// BEHAVIOUR
// - Reset (async, any state): SCLK=0, CS_N=1, MOSI=0, BUSY=0, DONE=0, RX_DATA=0,
//   state=IDLE, tick counter=0. Reset mid-transfer aborts the transfer at once.
// - Tick: counter runs 0..DIV_VAL_latched. tick=1 when counter==DIV_VAL_latched,
//   then the counter clears. The counter is held at 0 in IDLE.
//   Tick period = DIV_VAL+1 cycles. DIV_VAL=0 gives SCLK = CLK/2.
// - IDLE: on START, latch TX_DATA into tx_sh and DIV_VAL into div_q;
//   set CS_N<=0, MOSI<=TX_DATA[DATA_W-1], BUSY<=1, go to SETUP.
// - SETUP: SCLK stays 0. On tick, go to XFER.
// - XFER: toggle SCLK on each tick.
//   - Rising edge: rx_sh <= {rx_sh[DATA_W-2:0], MISO}; increment bit_cnt.
//   - Falling edge: shift tx_sh left; MOSI <= next MSB.
//   - After the DATA_W-th falling edge, SCLK=0 and state goes to HOLD.
//     MOSI is not updated on that final falling edge.
// - HOLD: on tick, set CS_N<=1, RX_DATA<=rx_sh, DONE<=1, BUSY<=0, go to IDLE.
// - Latency: DONE rises exactly (2*DATA_W+2)*(DIV_VAL+1) cycles after the first
//   BUSY=1 cycle. Example: DATA_W=8, DIV_VAL=0 gives 18 cycles.
// - START while BUSY=1 is ignored. TX_DATA and DIV_VAL changes are ignored
//   while BUSY=1.
// - START in the DONE cycle (state is already IDLE) is accepted. This allows
//   back-to-back transfers with one idle cycle, during which CS_N=1.
// - bit_cnt is $clog2(DATA_W+1) bits wide and has no wrap-around. The
//   tick counter compare is on CNT_W bits, so DIV_VAL = all-ones is legal.
// CONFIGURATION
// - SPI_XFER_CTRL_LOOPBACK_EN defined: the rising-edge sample takes MOSI instead
//   of MISO, and MISO is unused. RX_DATA equals the TX_DATA of the same transfer.
// - Not defined: samples MISO as described above.
// - Port list, timing and latency are identical in both builds.
// STRUCTURE
// - Shared package spi_pkg:
//   - state type: IDLE, SETUP, XFER, HOLD
//   - SPI_DIV_DEFAULT constant
//   - SPI_DATA_W_DEFAULT constant
// - Sub-module spi_tick_gen (CLK, RST, CLR, DIV, TICK): the programmable enable
//   divider. CLR holds the counter at 0. spi_xfer_ctrl holds the FSM and the
//   shift registers.
// TESTING
// - Reset during XFER (DIV_VAL=3, after 3 SCLK rises) -> outputs go to reset
//   values immediately. A new START then runs a full, correct transfer.
// - DIV_VAL=0, TX=0xA5, MISO driven by a bench slave returning 0x3C -> MOSI
//   bits 1,0,1,0,0,1,0,1 on SCLK rises; RX_DATA=0x3C; DONE 18 cycles after BUSY rises.
// - DIV_VAL=1, TX=0xFF, MISO=0 -> SCLK high/low 2 cycles each, 8 pulses;
//   DONE at 36 cycles; RX_DATA=0x00; exactly one DONE pulse.
// - START held high through a transfer -> second START ignored while BUSY. A new
//   transfer begins on the DONE cycle; CS_N high for exactly 1 cycle between.
// - DIV_VAL changed to 5 mid-transfer (latched 2) -> SCLK period stays 6
//   cycles until DONE. The next transfer uses period 12.
// - SPI_XFER_CTRL_LOOPBACK_EN build, TX=0x5A, MISO tied 1 -> RX_DATA=0x5A.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state type and defaults for the SPI transfer sequencer
package spi_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;
  localparam int SPI_DIV_DEFAULT = 0;
  localparam int SPI_DATA_W_DEFAULT = 8;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: programmable enable divider, TICK once every DIV+1 cycles, held at 0 by CLR
module spi_tick_gen #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic [CNT_W-1:0] DIV,
  output logic             TICK
);
  logic [CNT_W-1:0] cnt;
  assign TICK = cnt == DIV;
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= (CLR || TICK) ? '0 : cnt + CNT_W'(1);
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI mode-0 MSB-first master sequencer with START/BUSY/DONE handshake
// SPI_XFER_CTRL_LOOPBACK_EN samples MOSI instead of MISO on each rising SCLK edge
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [CNT_W-1:0]  DIV_VAL,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              CS_N
);
  localparam int BW = $clog2(DATA_W + 1);
  spi_state_t state, state_d;
  logic [CNT_W-1:0] div_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [BW-1:0] bit_cnt;
  logic tick, sample, last;
  spi_tick_gen #(.CNT_W(CNT_W)) u_tick (
    .CLK (CLK),
    .RST (RST),
    .CLR (state == IDLE),
    .DIV (div_q),
    .TICK(tick)
  );
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
  assign sample = MOSI;
`else
  assign sample = MISO;
`endif
  assign last = bit_cnt == BW'(DATA_W);
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = START ? SETUP : IDLE;
      SETUP:   state_d = tick ? XFER : SETUP;
      XFER:    state_d = (tick && SCLK && last) ? HOLD : XFER;
      HOLD:    state_d = tick ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      SCLK    <= 1'b0;
      CS_N    <= 1'b1;
      MOSI    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RX_DATA <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      bit_cnt <= '0;
      div_q   <= CNT_W'(SPI_DIV_DEFAULT);
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: if (START) begin
          tx_sh   <= TX_DATA;
          div_q   <= DIV_VAL;
          CS_N    <= 1'b0;
          MOSI    <= TX_DATA[DATA_W-1];
          BUSY    <= 1'b1;
          bit_cnt <= '0;
        end
        XFER: if (tick) begin
          SCLK <= ~SCLK;
          if (!SCLK) begin
            rx_sh   <= {rx_sh[DATA_W-2:0], sample};
            bit_cnt <= bit_cnt + BW'(1);
          end else if (!last) begin
            // the final falling edge leaves MOSI on the last data bit
            tx_sh <= tx_sh << 1;
            MOSI  <= tx_sh[DATA_W-2];
          end
        end
        HOLD: if (tick) begin
          CS_N    <= 1'b1;
          RX_DATA <= rx_sh;
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule
